// File: rtl/sine_cos_slope.sv
// Quadrature sine/cosine oscillator (Minsky recurrence) with a slope monitor on the sine output.
// Optional feature macro: SINE_COS_SLOPE_EDGE_EN enables the direction tracker and posen/negen pulses.
module sine_cos_slope #(
    parameter int WIDTH = 16,
    parameter int SHIFT = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    output logic signed [WIDTH-1:0] sine,
    output logic signed [WIDTH-1:0] cos,
    output logic                    eq,
    output logic                    pos,
    output logic                    neg,
    output logic                    posen,
    output logic                    negen
);

    localparam logic signed [WIDTH-1:0] AMP = {2'b01, {(WIDTH-2){1'b0}}};

    logic signed [WIDTH-1:0] cos_next;
    logic signed [WIDTH-1:0] sine_next;
    logic signed [WIDTH-1:0] prev;
    logic                    primed;
    logic                    rise;
    logic                    fall;
    logic                    same;

    // The new cosine feeds the sine update; this ordering keeps the orbit closed.
    always_comb begin
        cos_next  = cos - (sine >>> SHIFT);
        sine_next = sine + (cos_next >>> SHIFT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sine <= '0;
            cos  <= AMP;
        end else if (en) begin
            sine <= sine_next;
            cos  <= cos_next;
        end
    end

    // Comparison of the presented sine against the previously captured one.
    always_comb begin
        rise = primed && (sine > prev);
        fall = primed && (sine < prev);
        same = primed && (sine == prev);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev   <= '0;
            primed <= 1'b0;
            eq     <= 1'b0;
            pos    <= 1'b0;
            neg    <= 1'b0;
        end else begin
            prev   <= sine;
            primed <= 1'b1;
            eq     <= same;
            pos    <= rise;
            neg    <= fall;
        end
    end

`ifdef SINE_COS_SLOPE_EDGE_EN
    typedef enum logic [1:0] {NONE, UP, DOWN} dir_t;

    dir_t state;
    dir_t state_next;
    logic posen_next;
    logic negen_next;

    // Flat samples leave the direction alone so a plateau cannot fake a reversal.
    always_comb begin
        state_next = state;
        posen_next = 1'b0;
        negen_next = 1'b0;
        if (rise) begin
            state_next = UP;
            posen_next = (state == DOWN);
        end else if (fall) begin
            state_next = DOWN;
            negen_next = (state == UP);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= NONE;
            posen <= 1'b0;
            negen <= 1'b0;
        end else begin
            state <= state_next;
            posen <= posen_next;
            negen <= negen_next;
        end
    end
`else
    assign posen = 1'b0;
    assign negen = 1'b0;
`endif

endmodule

// File: tb/tb_sine_cos_slope.sv
// Directed bench for sine_cos_slope: hand-computed vectors plus a cycle model of the oscillator and slope flags.
module tb_sine_cos_slope;

    logic                clk = 1'b0;
    logic                reset;
    logic                en;
    logic signed [15:0]  sine;
    logic signed [15:0]  cos;
    logic                eq;
    logic                pos;
    logic                neg;
    logic                posen;
    logic                negen;

    int assertCount = 0;
    int failCount   = 0;

    int ms, mc, mprev, mstate;
    bit mprimed, meq, mpos, mneg, mposen, mnegen;

    int cycleIdx, posenCount, negenCount, lastPulseCycle, lastPulseType;
    int lastDir, reversalsUp, reversalsDown, sineMax, sineMin;

`ifdef SINE_COS_SLOPE_EDGE_EN
    localparam int EXP_NEGEN = 3;
    localparam int EXP_POSEN = 2;
    localparam int EXP_HOLD_NEGEN = 1;
`else
    localparam int EXP_NEGEN = 0;
    localparam int EXP_POSEN = 0;
    localparam int EXP_HOLD_NEGEN = 0;
`endif

    sine_cos_slope #(.WIDTH(16), .SHIFT(6)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .sine  (sine),
        .cos   (cos),
        .eq    (eq),
        .pos   (pos),
        .neg   (neg),
        .posen (posen),
        .negen (negen)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cycleIdx);
        end
    endtask

    task automatic modelReset();
        ms = 0; mc = 16384; mprev = 0; mstate = 0; mprimed = 0;
        meq = 0; mpos = 0; mneg = 0; mposen = 0; mnegen = 0;
    endtask

    task automatic modelEdge(input bit enNow);
        bit r, f;
        r = mprimed && (ms > mprev);
        f = mprimed && (ms < mprev);
        meq = mprimed && (ms == mprev);
        mpos = r;
        mneg = f;
        mposen = 0;
        mnegen = 0;
`ifdef SINE_COS_SLOPE_EDGE_EN
        if (r) begin
            mposen = (mstate == 2);
            mstate = 1;
        end else if (f) begin
            mnegen = (mstate == 1);
            mstate = 2;
        end
`endif
        mprimed = 1;
        mprev = ms;
        if (enNow) begin
            mc = mc - (ms >>> 6);
            ms = ms + (mc >>> 6);
        end
    endtask

    task automatic clearStats();
        posenCount = 0; negenCount = 0; lastPulseCycle = -1; lastPulseType = 0;
        lastDir = 0; reversalsUp = 0; reversalsDown = 0; sineMax = -99999; sineMin = 99999;
        cycleIdx = 0;
    endtask

    task automatic checkAll();
        checkOutput("sine", sine, ms);
        checkOutput("cos", cos, mc);
        checkOutput("eq", eq, meq);
        checkOutput("pos", pos, mpos);
        checkOutput("neg", neg, mneg);
        checkOutput("posen", posen, mposen);
        checkOutput("negen", negen, mnegen);
    endtask

    // One clock with the given enable; compare against the model and gather waveform statistics.
    task automatic applyStimulus(input bit enVal);
        en = enVal;
        @(posedge clk);
        modelEdge(enVal);
        @(negedge clk);
        cycleIdx++;
        checkAll();
        if (sine > sineMax) sineMax = sine;
        if (sine < sineMin) sineMin = sine;
        if (neg && lastDir == 1) reversalsDown++;
        if (pos && lastDir == 2) reversalsUp++;
        if (pos) lastDir = 1;
        if (neg) lastDir = 2;
        if (posen || negen) begin
            if (lastPulseCycle >= 0) begin
                checkOutput("pulse_spacing_ok",
                            int'((cycleIdx - lastPulseCycle) >= 190 && (cycleIdx - lastPulseCycle) <= 212), 1);
                checkOutput("pulse_alternates", int'((posen ? 1 : 2) != lastPulseType), 1);
            end
            lastPulseCycle = cycleIdx;
            lastPulseType  = posen ? 1 : 2;
        end
        if (posen) posenCount++;
        if (negen) negenCount++;
    endtask

    initial begin
        int holdPulses;
        reset = 1'b0;
        en    = 1'b0;
        modelReset();
        clearStats();
        #12;
        checkOutput("rst_sine", sine, 0);
        checkOutput("rst_cos", cos, 16384);
        checkOutput("rst_flags", {eq, pos, neg, posen, negen}, 0);

        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0);
        checkOutput("first_flags_zero", {eq, pos, neg}, 0);
        applyStimulus(1'b0);
        checkOutput("idle_eq", eq, 1);
        applyStimulus(1'b0);

        // First oscillator steps from the reset point.
        clearStats();
        applyStimulus(1'b1);
        checkOutput("step1_sine", sine, 256);
        checkOutput("step1_cos", cos, 16384);
        checkOutput("step1_eq", eq, 1);
        applyStimulus(1'b1);
        checkOutput("step2_sine", sine, 511);
        checkOutput("step2_cos", cos, 16380);
        checkOutput("step2_pos", pos, 1);
        for (int i = 0; i < 998; i++) applyStimulus(1'b1);
        checkOutput("run_negen_count", negenCount, EXP_NEGEN);
        checkOutput("run_posen_count", posenCount, EXP_POSEN);
        checkOutput("run_peaks_seen", reversalsDown, 3);
        checkOutput("run_valleys_seen", reversalsUp, 2);
        checkOutput("peak_in_range", int'(sineMax >= 15800 && sineMax <= 16900), 1);
        checkOutput("valley_in_range", int'(sineMin <= -15800 && sineMin >= -16900), 1);

        // Fresh start, then freeze mid-rise.
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        clearStats();
        for (int i = 0; i < 50; i++) applyStimulus(1'b1);
        holdPulses = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0);
            holdPulses += posen + negen;
        end
        checkOutput("hold_eq", eq, 1);
        checkOutput("hold_no_pulse", holdPulses, 0);
        posenCount = 0;
        negenCount = 0;
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("resume_pos", pos, 1);
        for (int i = 0; i < 58; i++) applyStimulus(1'b1);
        checkOutput("resume_no_posen", posenCount, 0);
        checkOutput("resume_peak_negen", negenCount, EXP_HOLD_NEGEN);

        // Asynchronous reset near the peak clears outputs without waiting for a clock.
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_sine", sine, 0);
        checkOutput("async_cos", cos, 16384);
        checkOutput("async_flags", {eq, pos, neg, posen, negen}, 0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        clearStats();
        for (int i = 0; i < 90; i++) applyStimulus(1'b1);
        checkOutput("post_reset_no_pulse", posenCount + negenCount, 0);
        for (int i = 0; i < 30; i++) applyStimulus(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/sine_cos_slope.md
# sine_cos_slope

Self-contained waveform source and slope monitor. A fixed-point quadrature oscillator produces signed sine/cosine samples. A slope detector watches the sine output and flags rising, falling and flat segments. It also emits single-cycle pulses at valleys and peaks, for use as a test stimulus source and as a zero-phase timing reference.

## Interface
- WIDTH, 16: sample width, signed two's complement, minimum 8
- SHIFT, 6: oscillator step shift; angular step = 2^-SHIFT rad/cycle
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  oscillator advance enable, sampled on clk
- sine  out  WIDTH  signed sine sample, registered
- cos  out  WIDTH  signed cosine sample, registered
- eq  out  1  current sine sample equals previous sample
- pos  out  1  current sine sample is greater than previous (signed)
- neg  out  1  current sine sample is less than previous (signed)
- posen  out  1  one-cycle pulse: slope turned positive (valley)
- negen  out  1  one-cycle pulse: slope turned negative (peak)

## Operation
- Oscillator uses the Minsky/modified-Euler recurrence with arithmetic (sign-preserving) shifts:
  - c' = c − (s >>> SHIFT)
  - s' = s + (c' >>> SHIFT)
  - The recurrence is bounded and needs no renormalisation.
- Reset values: sine = 0; cos = A = 2^(WIDTH−2) (16384 at WIDTH=16).
- Arithmetic is in WIDTH bits with wrap, which cannot occur since |s|, |c| ≤ ~1.01·A.
- en=1: one update per clock. en=0: sine and cos hold.
- Period ≈ 2π·2^SHIFT cycles (≈402 at SHIFT=6).
- Slope detector:
  - Registers the last sine sample (prev) and a primed bit.
  - Each clock, compares incoming sine against prev and registers exactly one of eq/pos/neg, then updates prev.
  - While unprimed (first clock after reset), all flags stay 0 and the sample is only captured.
- Direction state machine (registered):
  - States: NONE (reset), UP, DOWN.
  - pos moves to UP; neg moves to DOWN; eq holds the state.
  - posen = 1 on a clock where pos is registered while the state is DOWN.
  - negen = 1 on a clock where neg is registered while the state is UP.
  - No pulse out of NONE.
  - Flat runs (eq) between a rise and a fall do not suppress or duplicate a pulse.
- With en=0, the held sine gives eq=1, pos=neg=posen=negen=0.

## Timing
- All outputs are registered.
- All outputs are 0 during reset, except cos = A.
- sine/cos change on the edge where en=1 is sampled.
- Flags reflect the sine value present before edge k versus the one before edge k−1, registered at edge k.
  - Flags therefore lag a sine change by one clock.
- posen/negen are asserted for exactly one cycle, aligned with the first pos/neg cycle of the new direction.
- Reset asserted mid-operation:
  - Clears everything immediately (async).
  - Next rise of posen/negen requires a full direction history again.
- en toggling mid-cycle of the waveform only stretches time; direction state persists across holds.

## Configuration
- SINE_COS_SLOPE_EDGE_EN:
  - Defined: direction state machine, posen and negen as above.
  - Undefined: state machine omitted; posen and negen tied to 0; eq/pos/neg unaffected.

## Test plan
- Reset low, then release, en=0 -> sine=0, cos=16384, eq=pos=neg=0 first cycle, then eq=1 steady.
- en=1 after reset -> sine 0→256→511, cos 16384→16384→16380 on successive edges; pos=1 one clock after first change.
- Run 1000 cycles, en=1 -> sine peaks near +16384 with one negen per peak; valleys near −16384 with one posen each; pulse spacing ≈201 cycles, alternating.
- Drop en for 20 cycles mid-rise -> sine/cos hold, eq=1, no pulses; after en=1, pos resumes and no spurious posen.
- Assert reset mid-run at a peak region -> all flags 0, sine=0, cos=16384 immediately; no pulse until a full direction reversal.
- Build without SINE_COS_SLOPE_EDGE_EN, run 1000 cycles -> posen=negen=0 throughout; eq/pos/neg identical to the enabled build.
